// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed N-digit 7-segment driver with DP, blink, ghost blanking and frame snapshots.
// Optional LEAD_ZERO_BLANK_EN: suppress segments of digits above the most significant nonzero code.
module seg_scan_driver #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   code_in,
   input  logic [DIGITS-1:0]     dot_in,
   input  logic [DIGITS-1:0]     blink_in,
   output logic [0:7]            seg_out,
   output logic [DIGITS-1:0]     an_n,
   output logic                  frame_tick
);
   localparam int CW = $clog2(SCAN_DIV);
   localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
   localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CW-1:0] C_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYC);
   localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);
   localparam logic [FW-1:0] F_LAST  = FW'(BLINK_FRAMES - 1);

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [FW-1:0]       fcnt;
   logic                hidden, first;
   logic [4*DIGITS-1:0] snap_code;
   logic [DIGITS-1:0]   snap_dot, snap_blink, show;
   logic [3:0]          cur_code;
   logic                cur_dot, cur_blink, cur_show, slot_end, wrap, blank;
   logic [6:0]          seg7;

   always_comb begin
      cur_code  = '0;
      cur_dot   = 1'b0;
      cur_blink = 1'b0;
      cur_show  = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (idx == IW'(i)) begin
            cur_code  = snap_code[4*i +: 4];
            cur_dot   = snap_dot[i];
            cur_blink = snap_blink[i];
            cur_show  = show[i];
         end
   end

`ifdef LEAD_ZERO_BLANK_EN
   logic keep;
   // Scan from the top digit down; once a nonzero code is seen every lower digit is shown.
   always_comb begin
      keep = 1'b0;
      show = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         keep    = keep | (|snap_code[4*i +: 4]) | (i == 0);
         show[i] = keep;
      end
   end
`else
   assign show = '1;
`endif

   always_comb
      case (cur_code)
         4'd0:    seg7 = 7'b0000001;
         4'd1:    seg7 = 7'b1001111;
         4'd2:    seg7 = 7'b0010010;
         4'd3:    seg7 = 7'b0000110;
         4'd4:    seg7 = 7'b1001100;
         4'd5:    seg7 = 7'b0100100;
         4'd6:    seg7 = 7'b0100000;
         4'd7:    seg7 = 7'b0001111;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0000100;
         4'd10:   seg7 = 7'b0001000;
         4'd11:   seg7 = 7'b1100000;
         4'd14:   seg7 = 7'b0110000;
         4'd15:   seg7 = 7'b1110001;
         default: seg7 = 7'b0011000;
      endcase

   assign slot_end = cnt == C_LAST;
   assign wrap     = en && slot_end && idx == I_LAST;
   assign blank    = !en || cnt < C_BLANK || (hidden && cur_blink);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt        <= '0;
         idx        <= '0;
         fcnt       <= '0;
         hidden     <= 1'b0;
         first      <= 1'b1;
         snap_code  <= '0;
         snap_dot   <= '0;
         snap_blink <= '0;
         seg_out    <= '1;
         an_n       <= '1;
         frame_tick <= 1'b0;
      end else begin
         first <= 1'b0;
         if (en) begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) idx <= idx == I_LAST ? '0 : idx + 1'b1;
         end
         if (wrap) begin
            fcnt <= fcnt == F_LAST ? '0 : fcnt + 1'b1;
            if (fcnt == F_LAST) hidden <= !hidden;
         end
         if (first || wrap) begin
            snap_code  <= code_in;
            snap_dot   <= dot_in;
            snap_blink <= blink_in;
         end
         frame_tick <= wrap;
         an_n       <= blank ? '1 : ~(DIGITS'(1) << idx);
         seg_out    <= blank ? '1 : {cur_show ? seg7 : 7'h7F, ~cur_dot};
      end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench; stimulus pushes per-cycle expectations, a monitor pops and compares.
module tb_seg_scan_driver;
   logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1;
   logic [15:0] code = 16'h1234;
   logic [3:0]  dot = 4'b0010, blink = 4'b0000;
   logic [7:0]  seg;
   logic [3:0]  an;
   logic        ft;
   int          total = 0, bad = 0;
   logic [12:0] q[$];

   seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .BLINK_FRAMES(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .code_in(code), .dot_in(dot), .blink_in(blink),
      .seg_out(seg), .an_n(an), .frame_tick(ft)
   );

   always #5 clk = ~clk;

   logic [6:0] dec_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                7'b0011000, 7'b0011000, 7'b0110000, 7'b1110001};

   // Model state in scan-step terms: s counts enabled cycles since reset release.
   int          s = 0;
   bit          first = 1'b1;
   logic [15:0] mc = '0;
   logic [3:0]  md = '0, mb = '0;

   task automatic check(string name, logic [12:0] got, logic [12:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got an/seg/tick=%h expected %h", name, $time, got, exp);
      end
   endtask

   always begin
      @(posedge clk);
      #1;
      if (q.size() > 0) check("scan", {an, seg, ft}, q.pop_front());
   end

   task automatic tick();
      int c = s % 4, d = (s / 4) % 4, f = s / 16;
      logic [3:0] an_e = 4'hF;
      logic [7:0] seg_e = 8'hFF;
      logic       show = 1'b1, tk;
`ifdef LEAD_ZERO_BLANK_EN
      show = d == 0 || (mc >> (4 * d)) != 0;
`endif
      if (en && c >= 1 && !((f / 2) % 2 == 1 && mb[d])) begin
         an_e  = ~(4'b0001 << d);
         seg_e = {show ? dec_tab[mc[4*d +: 4]] : 7'h7F, ~md[d]};
      end
      tk = en && s % 16 == 15;
      q.push_back({an_e, seg_e, tk});
      if (first || tk) {mc, md, mb} = {code, dot, blink};
      first = 1'b0;
      if (en) s++;
      @(negedge clk);
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset", {an, seg, ft}, {4'hF, 8'hFF, 1'b0});
      rst_n = 1'b1;
      run(20);
      code = 16'h5678;
      run(28);
      blink = 4'b0001;
      run(98);
      while (s % 4 != 2) tick();
      en = 1'b0;
      run(10);
      en = 1'b1;
      run(12);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("async_reset", {an, seg, ft}, {4'hF, 8'hFF, 1'b0});
      @(negedge clk);
      @(negedge clk);
      check("reset_hold", {an, seg, ft}, {4'hF, 8'hFF, 1'b0});
      {s, first, mc, md, mb} = {32'd0, 1'b1, 16'h0, 4'h0, 4'h0};
      code  = 16'h0070;
      dot   = 4'b0000;
      blink = 4'b0000;
      rst_n = 1'b1;
      run(20);
      code = 16'h0000;
      run(32);
      @(posedge clk);
      #2;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
